// File: rtl/control_unit.sv
// +------------------------------------------------------------------+
// | control_unit: sequencing FSM for the simple bus-based CPU         |
// |   fetch / decode / execute control with combinational outputs     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic       zero,
  output logic       load_R0,
  output logic       load_R1,
  output logic       load_R2,
  output logic       load_R3,
  output logic       load_PC,
  output logic       inc_PC,
  output logic       load_IR,
  output logic       load_Add_R,
  output logic       load_Reg_Y,
  output logic       load_Reg_Z,
  output logic [2:0] sel_Bus_1_Mux,
  output logic [1:0] sel_Bus_2_Mux,
  output logic       write
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_PC    = 3'd4;
  localparam logic [1:0] SEL2_ALU   = 2'd0;
  localparam logic [1:0] SEL2_BUS1  = 2'd1;
  localparam logic [1:0] SEL2_MEM   = 2'd2;

  state_t     r_state;
  logic [3:0] w_opcode;
  logic [1:0] w_src;
  logic [1:0] w_dest;
  logic [3:0] w_load_r;

  assign w_opcode = instruction[7:4];
  assign w_src    = instruction[3:2];
  assign w_dest   = instruction[1:0];

  assign load_R0 = w_load_r[0];
  assign load_R1 = w_load_r[1];
  assign load_R2 = w_load_r[2];
  assign load_R3 = w_load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FET1;
        S_FET1: r_state <= S_FET2;
        S_FET2: r_state <= S_DEC;
        S_DEC: begin
          case (w_opcode)
            OP_NOP, OP_NOT:         r_state <= S_FET1;
            OP_ADD, OP_SUB, OP_AND: r_state <= S_EX1;
            OP_RD:                  r_state <= S_RD1;
            OP_WR:                  r_state <= S_WR1;
            OP_BR:                  r_state <= S_BR1;
            OP_BRZ:                 r_state <= zero ? S_BR1 : S_FET1;
            default:                r_state <= S_HALT;
          endcase
        end
        S_EX1:  r_state <= S_FET1;
        S_RD1:  r_state <= S_RD2;
        S_RD2:  r_state <= S_FET1;
        S_WR1:  r_state <= S_WR2;
        S_WR2:  r_state <= S_FET1;
        S_BR1:  r_state <= S_BR2;
        S_BR2:  r_state <= S_FET1;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    w_load_r      = 4'b0000;
    load_PC       = 1'b0;
    inc_PC        = 1'b0;
    load_IR       = 1'b0;
    load_Add_R    = 1'b0;
    load_Reg_Y    = 1'b0;
    load_Reg_Z    = 1'b0;
    sel_Bus_1_Mux = 3'd0;
    sel_Bus_2_Mux = 2'd0;
    write         = 1'b0;
    case (r_state)
      S_FET1: begin
        sel_Bus_1_Mux = SEL1_PC;
        sel_Bus_2_Mux = SEL2_BUS1;
        load_Add_R    = 1'b1;
      end
      S_FET2: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_IR       = 1'b1;
        inc_PC        = 1'b1;
      end
      S_DEC: begin
        case (w_opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel_Bus_1_Mux = {1'b0, w_src};
            load_Reg_Y    = 1'b1;
          end
          OP_NOT: begin
            sel_Bus_1_Mux    = {1'b0, w_src};
            sel_Bus_2_Mux    = SEL2_ALU;
            load_Reg_Z       = 1'b1;
            w_load_r[w_dest] = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_Bus_1_Mux = SEL1_PC;
            sel_Bus_2_Mux = SEL2_BUS1;
            load_Add_R    = 1'b1;
          end
          OP_BRZ: begin
            // Not taken: step PC past the inline branch address word
            if (zero) begin
              sel_Bus_1_Mux = SEL1_PC;
              sel_Bus_2_Mux = SEL2_BUS1;
              load_Add_R    = 1'b1;
            end else begin
              inc_PC = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        sel_Bus_1_Mux    = {1'b0, w_dest};
        sel_Bus_2_Mux    = SEL2_ALU;
        load_Reg_Z       = 1'b1;
        w_load_r[w_dest] = 1'b1;
      end
      S_RD1, S_WR1: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_Add_R    = 1'b1;
        inc_PC        = 1'b1;
      end
      S_RD2: begin
        sel_Bus_2_Mux    = SEL2_MEM;
        w_load_r[w_dest] = 1'b1;
      end
      S_WR2: begin
        sel_Bus_1_Mux = {1'b0, w_src};
        write         = 1'b1;
      end
      S_BR1: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_Add_R    = 1'b1;
      end
      S_BR2: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_PC       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// +------------------------------------------------------------------+
// | tb_control_unit: randomized self-checking bench for control_unit  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z;
  logic [2:0] sel_Bus_1_Mux;
  logic [1:0] sel_Bus_2_Mux;
  logic       write;

  typedef struct packed {
    logic [3:0] ld_r;
    logic       ld_pc;
    logic       inc_pc;
    logic       ld_ir;
    logic       ld_add;
    logic       ld_y;
    logic       ld_z;
    logic [2:0] s1;
    logic [1:0] s2;
    logic       wr;
  } out_t;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .zero          (zero),
    .load_R0       (load_R0),
    .load_R1       (load_R1),
    .load_R2       (load_R2),
    .load_R3       (load_R3),
    .load_PC       (load_PC),
    .inc_PC        (inc_PC),
    .load_IR       (load_IR),
    .load_Add_R    (load_Add_R),
    .load_Reg_Y    (load_Reg_Y),
    .load_Reg_Z    (load_Reg_Z),
    .sel_Bus_1_Mux (sel_Bus_1_Mux),
    .sel_Bus_2_Mux (sel_Bus_2_Mux),
    .write         (write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observed();
    out_t o;
    o.ld_r   = {load_R3, load_R2, load_R1, load_R0};
    o.ld_pc  = load_PC;
    o.inc_pc = inc_PC;
    o.ld_ir  = load_IR;
    o.ld_add = load_Add_R;
    o.ld_y   = load_Reg_Y;
    o.ld_z   = load_Reg_Z;
    o.s1     = sel_Bus_1_Mux;
    o.s2     = sel_Bus_2_Mux;
    o.wr     = write;
    return o;
  endfunction

  // Instruction length in cycles, from the opcode and the zero flag seen at decode
  function automatic int cycles(input logic [7:0] ins, input logic z);
    int op;
    op = int'(ins[7:4]);
    if (op == 0 || op == 4) return 3;
    if (op >= 1 && op <= 3) return 4;
    if (op >= 5 && op <= 7) return 5;
    if (op == 8) return z ? 5 : 3;
    return 3;
  endfunction

  // Micro-step table: what the controls must be on step s of instruction ins
  function automatic out_t model(input logic [7:0] ins, input logic z, input int s);
    out_t o;
    int op;
    o  = '0;
    op = int'(ins[7:4]);
    case (s)
      0: begin o.s1 = 3'd4; o.s2 = 2'd1; o.ld_add = 1'b1; end
      1: begin o.s2 = 2'd2; o.ld_ir = 1'b1; o.inc_pc = 1'b1; end
      2: begin
        if (op >= 1 && op <= 3) begin
          o.s1 = {1'b0, ins[3:2]}; o.ld_y = 1'b1;
        end else if (op == 4) begin
          o.s1 = {1'b0, ins[3:2]}; o.ld_z = 1'b1; o.ld_r = 4'b0001 << ins[1:0];
        end else if ((op >= 5 && op <= 7) || (op == 8 && z)) begin
          o.s1 = 3'd4; o.s2 = 2'd1; o.ld_add = 1'b1;
        end else if (op == 8) begin
          o.inc_pc = 1'b1;
        end
      end
      3: begin
        if (op >= 1 && op <= 3) begin
          o.s1 = {1'b0, ins[1:0]}; o.ld_z = 1'b1; o.ld_r = 4'b0001 << ins[1:0];
        end else begin
          o.s2 = 2'd2; o.ld_add = 1'b1; o.inc_pc = (op == 5 || op == 6);
        end
      end
      4: begin
        if (op == 5) begin
          o.s2 = 2'd2; o.ld_r = 4'b0001 << ins[1:0];
        end else if (op == 6) begin
          o.s1 = {1'b0, ins[3:2]}; o.wr = 1'b1;
        end else begin
          o.s2 = 2'd2; o.ld_pc = 1'b1;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  // Runs up to max_steps cycles of one instruction starting in fetch-1.
  // zsel: 0/1 forces zero at decode, 2 randomizes it.
  task automatic run_instr(input logic [7:0] ins, input int zsel, input int max_steps);
    int   n;
    logic zdec;
    out_t got, exp;
    n    = 3;
    zdec = 1'b0;
    for (int s = 0; s < n && s < max_steps; s++) begin
      @(negedge clk);
      instruction = (s < 2) ? 8'($urandom) : ins;
      zero = (s == 2 && zsel != 2) ? zsel[0] : 1'($urandom);
      if (s == 2) begin
        zdec = zero;
        n    = cycles(ins, zdec);
      end
      #1;
      got = observed();
      exp = model(ins, zdec, s);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL instr %h step %0d (z=%0b): got %h expected %h", ins, s, zdec, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    out_t got;
    @(negedge clk);
    rst = 1'b0;
    instruction = 8'($urandom);
    zero = 1'($urandom);
    #1;
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got %h expected 0", got);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h expected 0", got);
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) run_instr(8'h00, 2, 99);
  endtask

  task automatic test_alu();
    run_instr(8'h16, 2, 99);
    run_instr(8'h2B, 2, 99);
    run_instr(8'h3C, 2, 99);
    run_instr(8'h4E, 2, 99);
  endtask

  task automatic test_rd_wr();
    run_instr(8'h53, 2, 99);
    run_instr(8'h64, 2, 99);
    run_instr(8'h70, 2, 99);
  endtask

  task automatic test_brz();
    run_instr(8'h80, 1, 99);
    run_instr(8'h80, 0, 99);
    run_instr(8'h8D, 1, 99);
    run_instr(8'h87, 0, 99);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ins;
    for (int i = 0; i < 60; i++) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom)};
      run_instr(ins, 2, 99);
    end
  endtask

  task automatic test_halt();
    out_t got;
    int   bad;
    logic [7:0] ins;
    ins = {4'($urandom_range(9, 15)), 4'($urandom)};
    run_instr(ins, 2, 99);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      instruction = 8'($urandom);
      zero = 1'($urandom);
      #1;
      got = observed();
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL halt_cycle %0d (instr %h): got %h expected 0", i, ins, got);
      end
    end
    test_reset();
    run_instr(8'h00, 2, 99);
    run_instr(8'h16, 2, 99);
  endtask

  task automatic test_async_reset();
    out_t got;
    run_instr(8'h53, 2, 4);
    #1;
    rst = 1'b0;
    #1;
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL async_reset_immediate: got %h expected 0", got);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instruction = 8'($urandom);
      #1;
      got = observed();
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL async_reset_hold %0d: got %h expected 0", i, got);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    instruction = 8'h53;
    #1;
    got = observed();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL async_reset_idle: got %h expected 0", got);
    end
    run_instr(8'h53, 2, 99);
    run_instr(8'h64, 2, 99);
  endtask

  initial begin
    rst = 1'b0;
    instruction = 8'h00;
    zero = 1'b0;
    test_reset();
    test_nop();
    test_alu();
    test_rd_wr();
    test_brz();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
